// File: rtl/carregador_operandos_pkg.sv
// Shared types and constants for the operand loader: FSM state encoding
// and the byte-slot layout of the 7-byte X/A/B/C frame.
package carregador_operandos_pkg;

  typedef enum logic [1:0] {
    RECEBE  = 2'd0,
    DISPARA = 2'd1,
    ESPERA  = 2'd2,
    ENTREGA = 2'd3
  } estado_t;

  localparam int unsigned FRAME_LEN = 7;

  localparam logic [2:0] SLOT_X    = 3'd0;
  localparam logic [2:0] SLOT_A_HI = 3'd1;
  localparam logic [2:0] SLOT_A_LO = 3'd2;
  localparam logic [2:0] SLOT_B_HI = 3'd3;
  localparam logic [2:0] SLOT_B_LO = 3'd4;
  localparam logic [2:0] SLOT_C_HI = 3'd5;
  localparam logic [2:0] SLOT_C_LO = 3'd6;

endpackage

// File: rtl/carregador_operandos_if.sv
// Byte-stream input handshake and result output handshake of the loader.
// master = upstream producer / result consumer, slave = the loader itself.
interface carregador_operandos_if;

  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] res_out;
  logic        ovf_out;
  logic        erro;
  logic        res_valid;
  logic        res_ack;

  modport master (
    output byte_in, byte_valid, res_ack,
    input  byte_ready, res_out, ovf_out, erro, res_valid
  );

  modport slave (
    input  byte_in, byte_valid, res_ack,
    output byte_ready, res_out, ovf_out, erro, res_valid
  );

endinterface

// File: rtl/carregador_operandos_detector_borda.sv
// Rising-edge detector: remembers last cycle's sample and flags a 0->1 change.
// Synchronous active-low reset.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev_d;
  logic prev_q;

  always_comb begin
    prev_d = d;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; reset is synchronous, so it sits inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/carregador_operandos.sv
// Operand loader / job dispatcher: assembles X, A, B, C from a byte stream,
// pulses START, waits for finished (or timeout) and presents the result.
module carregador_operandos
  import carregador_operandos_pkg::*;
#(
  parameter int unsigned START_LEN = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 RST,
  carregador_operandos_if.slave bus,
  output logic [7:0]           X,
  output logic [15:0]          A,
  output logic [15:0]          B,
  output logic [15:0]          C,
  output logic                 START,
  input  logic                 finished,
  input  logic                 Overflow,
  input  logic [15:0]          Resultado,
  output logic                 busy
);

  localparam logic [2:0]  SLOT_LAST  = 3'(FRAME_LEN - 1);
  localparam logic [3:0]  START_LAST = 4'(START_LEN - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

  estado_t     state_d, state_q;
  logic [2:0]  cnt_d, cnt_q;
  logic [7:0]  x_d, x_q;
  logic [15:0] a_d, a_q, b_d, b_q, c_d, c_q;
  logic [3:0]  start_cnt_d, start_cnt_q;
  logic [15:0] tmo_d, tmo_q;
  logic        ovf_sticky_d, ovf_sticky_q;
  logic [15:0] res_out_d, res_out_q;
  logic        ovf_out_d, ovf_out_q;
  logic        erro_d, erro_q;
  logic        res_valid_d, res_valid_q;
  logic        start_d, start_q;
  logic        busy_d, busy_q;
  logic        byte_ready_d, byte_ready_q;
  logic        fin_rise;

  detector_borda u_borda (
    .clk   (clk),
    .rst_n (RST),
    .d     (finished),
    .rise  (fin_rise)
  );

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    start_cnt_d  = start_cnt_q;
    tmo_d        = tmo_q;
    ovf_sticky_d = ovf_sticky_q;
    res_out_d    = res_out_q;
    ovf_out_d    = ovf_out_q;
    erro_d       = erro_q;
    res_valid_d  = res_valid_q;
    start_d      = 1'b0;

    unique case (state_q)
      RECEBE: begin
        if (bus.byte_valid && byte_ready_q) begin
          unique case (cnt_q)
            SLOT_X:    x_d       = bus.byte_in;
            SLOT_A_HI: a_d[15:8] = bus.byte_in;
            SLOT_A_LO: a_d[7:0]  = bus.byte_in;
            SLOT_B_HI: b_d[15:8] = bus.byte_in;
            SLOT_B_LO: b_d[7:0]  = bus.byte_in;
            SLOT_C_HI: c_d[15:8] = bus.byte_in;
            SLOT_C_LO: c_d[7:0]  = bus.byte_in;
            default: ;
          endcase
          if (cnt_q == SLOT_LAST) begin
            cnt_d        = '0;
            state_d      = DISPARA;
            start_d      = 1'b1;
            start_cnt_d  = '0;
            tmo_d        = '0;
            ovf_sticky_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      DISPARA: begin
        if (start_cnt_q == START_LAST) begin
          state_d = ESPERA;
        end else begin
          start_cnt_d = start_cnt_q + 4'd1;
          start_d     = 1'b1;
        end
      end
      ESPERA: begin
        ovf_sticky_d = ovf_sticky_q | Overflow;
        // A finished edge takes priority over a timeout landing on the same cycle.
        if (fin_rise) begin
          state_d     = ENTREGA;
          res_out_d   = Resultado;
          ovf_out_d   = ovf_sticky_q | Overflow;
          erro_d      = 1'b0;
          res_valid_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ENTREGA;
          res_out_d   = '0;
          ovf_out_d   = ovf_sticky_q;
          erro_d      = 1'b1;
          res_valid_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ENTREGA: begin
        if (bus.res_ack) begin
          state_d     = RECEBE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = RECEBE;
    endcase

    busy_d       = (state_d != RECEBE);
    byte_ready_d = (state_d == RECEBE);
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q      <= RECEBE;
      cnt_q        <= '0;
      x_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      start_cnt_q  <= '0;
      tmo_q        <= '0;
      ovf_sticky_q <= 1'b0;
      res_out_q    <= '0;
      ovf_out_q    <= 1'b0;
      erro_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      byte_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      start_cnt_q  <= start_cnt_d;
      tmo_q        <= tmo_d;
      ovf_sticky_q <= ovf_sticky_d;
      res_out_q    <= res_out_d;
      ovf_out_q    <= ovf_out_d;
      erro_q       <= erro_d;
      res_valid_q  <= res_valid_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      byte_ready_q <= byte_ready_d;
    end
  end

  assign X             = x_q;
  assign A             = a_q;
  assign B             = b_q;
  assign C             = c_q;
  assign START         = start_q;
  assign busy          = busy_q;
  assign bus.byte_ready = byte_ready_q;
  assign bus.res_out   = res_out_q;
  assign bus.ovf_out   = ovf_out_q;
  assign bus.erro      = erro_q;
  assign bus.res_valid = res_valid_q;

endmodule

// File: doc/carregador_operandos.md
Name: carregador_operandos

Overview:
Upstream operand loader and job dispatcher for the polynomial datapath (bloco_controle + bloco_operacional).
- Assembles X, A, B and C from a byte stream arriving on a valid/ready handshake.
- Fires START, then waits for finished.
- Captures Resultado plus a sticky Overflow and presents them on a result handshake.

Parameters:
START_LEN, 1, number of cycles START is held high per job (1..15).
TIMEOUT, 255, max cycles in ESPERA before aborting with erro (1..65535).

Ports:
clk  in  1  system clock, all logic on rising edge
RST  in  1  synchronous reset, active-low
byte_in  in  8  operand byte stream
byte_valid  in  1  byte_in valid
byte_ready  out  1  loader accepts a byte this cycle
X  out  8  operand X to datapath
A  out  16  operand A to datapath
B  out  16  operand B to datapath
C  out  16  operand C to datapath
START  out  1  start request to bloco_controle
finished  in  1  completion flag from bloco_controle
Overflow  in  1  overflow flag from bloco_operacional
Resultado  in  16  result from bloco_operacional
res_out  out  16  captured result
ovf_out  out  1  sticky overflow for the job
erro  out  1  job aborted by timeout
res_valid  out  1  res_out/ovf_out/erro valid
res_ack  in  1  consumer takes result
busy  out  1  high in DISPARA/ESPERA/ENTREGA

Behaviour:
Clock and reset (already decided):
- One clock, clk.
- RST is synchronous, active-low: sampled on rising clk; RST=0 resets everything next edge, including mid-job.
- Reset values: state RECEBE, byte counter 0, X/A/B/C=0, START=0, res_out=0, ovf_out=0, erro=0, res_valid=0, busy=0, timeout counter 0, edge register 0.

Frame format (7 bytes):
- byte0=X.
- byte1=A[15:8], byte2=A[7:0].
- byte3=B[15:8], byte4=B[7:0].
- byte5=C[15:8], byte6=C[7:0].

States:
- RECEBE
  - byte_ready=1.
  - A byte is accepted when byte_valid&&byte_ready; it is written into its operand register slot on that edge and the counter increments.
  - Acceptance of byte6 -> DISPARA; counter resets to 0.
- DISPARA
  - START=1 for exactly START_LEN cycles, then -> ESPERA.
  - The timeout counter and sticky overflow clear on entry.
- ESPERA
  - START=0. Each cycle: ovf_sticky |= Overflow.
  - Rising edge of finished (finished=1 and previous sample 0) -> ENTREGA with res_out=Resultado, ovf_out=ovf_sticky|Overflow, erro=0.
  - Timeout counter reaching TIMEOUT -> ENTREGA with res_out=0, ovf_out=ovf_sticky, erro=1.
  - finished edge and timeout in the same cycle: finished wins.
- ENTREGA
  - res_valid=1; outputs held stable.
  - res_ack=1 -> RECEBE next cycle with res_valid=0.
  - res_ack while res_valid=0 is ignored.

Operand and handshake rules:
- X/A/B/C change only on byte acceptance, so they are stable from DISPARA through ENTREGA.
- byte_valid outside RECEBE is ignored (byte_ready=0, nothing consumed).
- finished already high on entry to ESPERA does not count; a fresh rising edge is required.
- The edge register tracks finished in every state.
- Latency: START rises the cycle after byte6 is accepted; res_valid rises the cycle after the finished edge.

Decomposition:
- Shared package: state encoding (RECEBE, DISPARA, ESPERA, ENTREGA), FRAME_LEN=7, byte-slot offset constants.
- One sub-module: detector_borda (registered rising-edge detector, synchronous active-low reset), used on finished.

Test Plan:
- Frame FE 00 01 00 04 00 05 -> X=8'hFE, A=1, B=4, C=5. START high 1 cycle after byte6. Model finished edge 10 cycles later with Resultado=16'h0001 and an Overflow pulse mid-job -> res_out=16'h0001, ovf_out=1, erro=0, res_valid=1.
- Same frame with byte_valid toggled 1/0 every cycle -> identical operands; byte_ready low from DISPARA until res_ack; extra bytes sent while busy are not consumed.
- finished never rises, TIMEOUT=20 -> res_valid at cycle 21 of ESPERA; erro=1, res_out=0.
- res_ack held low 50 cycles -> res_valid and res_out stable. res_ack=1 -> next cycle res_valid=0 and byte_ready=1; a second frame 02 00 01 00 00 00 03 loads X=2, A=1, C=3.
- RST=0 asserted during ESPERA after 3 bytes of the next frame queued -> next edge all outputs at reset values; a subsequent full frame loads correctly from byte0.
- finished held high from before DISPARA, falls, then rises -> capture only on the later rising edge; START_LEN=3 -> START high exactly 3 cycles.
